// File: rtl/regfile_sequencer.sv
// Multi-cycle instruction sequencer: GPR file (r0 = 0) plus HI/LO, driving an external
// start/done ALU through READ -> EXEC -> WB, with a watchdog that aborts a silent ALU.
module regfile_sequencer #(
  parameter int DATA_W  = 32,
  parameter int NREGS   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  ir_valid,
  output logic                  ir_ready,
  input  logic [31:0]           ir,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [4:0]            alu_op,
  output logic                  alu_start,
  input  logic                  alu_done,
  input  logic [2*DATA_W-1:0]   alu_result,
  output logic                  wb_valid,
  output logic [3:0]            wb_sel,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  busy,
  output logic                  err,
  output logic [DATA_W-1:0]     hi,
  output logic [DATA_W-1:0]     lo,
  input  logic [3:0]            dbg_sel,
  output logic [DATA_W-1:0]     dbg_data
);

  // state | meaning
  // IDLE  | waiting for an instruction, ir_ready high
  // READ  | operands latched, watchdog loading
  // EXEC  | alu_start on first cycle, then waiting for alu_done or timeout
  // WB    | writeback of the captured result to a GPR or HI/LO
  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  localparam int             WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_TC  = WD_W'(TIMEOUT);
  localparam logic [4:0]     NREGS_W = 5'(NREGS);
  localparam logic [4:0]     OP_MUL  = 5'b01100;
  localparam logic [4:0]     OP_DIV  = 5'b01101;

  state_t                r_state;
  state_t                w_next;
  logic [4:0]            r_op;
  logic [3:0]            r_dst;
  logic [DATA_W-1:0]     r_alu_a;
  logic [DATA_W-1:0]     r_alu_b;
  logic [2*DATA_W-1:0]   r_res;
  logic [DATA_W-1:0]     r_hi;
  logic [DATA_W-1:0]     r_lo;
  logic [WD_W-1:0]       r_wd;
  logic [DATA_W-1:0]     r_gpr [NREGS];

  logic w_accept;
  logic w_first;
  logic w_done;
  logic w_timeout;
  logic w_muldiv;
  logic w_dst_ok;

  function automatic logic [DATA_W-1:0] f_rd(input logic [3:0] sel);
    if (sel != 4'd0 && {1'b0, sel} < NREGS_W) return r_gpr[sel];
    return '0;
  endfunction

  assign w_accept  = (r_state == S_IDLE) && ir_valid;
  assign w_first   = (r_state == S_EXEC) && (r_wd == WD_TC);
  // alu_done is ignored in the alu_start cycle; it wins over a timeout on the last cycle
  assign w_done    = (r_state == S_EXEC) && !w_first && alu_done;
  assign w_timeout = (r_state == S_EXEC) && (r_wd == '0) && !alu_done;
  assign w_muldiv  = (r_op == OP_MUL) || (r_op == OP_DIV);
  assign w_dst_ok  = (r_dst != 4'd0) && ({1'b0, r_dst} < NREGS_W);

  always_ff @(posedge clk) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    ir_ready  = 1'b0;
    busy      = 1'b1;
    alu_start = 1'b0;
    err       = 1'b0;
    wb_valid  = 1'b0;
    wb_sel    = 4'd0;
    wb_data   = '0;
    case (r_state)
      S_IDLE: begin
        ir_ready = 1'b1;
        busy     = 1'b0;
        if (ir_valid) w_next = S_READ;
      end
      S_READ: w_next = S_EXEC;
      S_EXEC: begin
        alu_start = w_first;
        if (w_done) begin
          w_next = S_WB;
        end else if (w_timeout) begin
          err    = !clr;
          w_next = S_IDLE;
        end
      end
      S_WB: begin
        wb_valid = !clr;
        wb_sel   = w_muldiv ? 4'd0 : r_dst;
        wb_data  = r_res[DATA_W-1:0];
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_op    <= '0;
      r_dst   <= '0;
      r_alu_a <= '0;
      r_alu_b <= '0;
      r_res   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_wd    <= '0;
      for (int i = 0; i < NREGS; i++) r_gpr[i] <= '0;
    end else begin
      // operands are read at the handshake edge, so a WB from the previous
      // instruction is already visible here
      if (w_accept) begin
        r_op    <= ir[31:27];
        r_dst   <= ir[26:23];
        r_alu_a <= ir[31] ? {{(DATA_W-15){1'b0}}, ir[14:0]} : f_rd(ir[22:19]);
        r_alu_b <= f_rd(ir[18:15]);
      end
      if (r_state == S_READ)
        r_wd <= WD_TC;
      else if (r_state == S_EXEC && r_wd != '0)
        r_wd <= r_wd - WD_W'(1);
      if (w_done) r_res <= alu_result;
      if (r_state == S_WB) begin
        if (w_muldiv) begin
          r_hi <= r_res[2*DATA_W-1:DATA_W];
          r_lo <= r_res[DATA_W-1:0];
        end else if (w_dst_ok) begin
          r_gpr[r_dst] <= r_res[DATA_W-1:0];
        end
      end
    end
  end

  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign alu_op   = r_op;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign dbg_data = f_rd(dbg_sel);

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench for regfile_sequencer: hand-computed vector table, corner
// sequences (mul, watchdog, reset mid-op) and random instructions against a register model.
module tb_regfile_sequencer;

  localparam int DW = 32;
  localparam int NR = 12;
  localparam int T  = 20;

  logic          clk = 1'b0;
  logic          clr;
  logic          ir_valid;
  logic          ir_ready;
  logic [31:0]   ir;
  logic [DW-1:0] alu_a, alu_b;
  logic [4:0]    alu_op;
  logic          alu_start;
  logic          alu_done;
  logic [2*DW-1:0] alu_result;
  logic          wb_valid;
  logic [3:0]    wb_sel;
  logic [DW-1:0] wb_data;
  logic          busy, err;
  logic [DW-1:0] hi, lo;
  logic [3:0]    dbg_sel;
  logic [DW-1:0] dbg_data;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_sequencer #(.DATA_W(DW), .NREGS(NR), .TIMEOUT(T)) dut (
    .clk(clk), .clr(clr), .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result), .wb_valid(wb_valid),
    .wb_sel(wb_sel), .wb_data(wb_data), .busy(busy), .err(err), .hi(hi), .lo(lo),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // behavioural ALU: result is presented continuously, alu_done decides when it counts
  function automatic logic [63:0] f_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'b00001: return {32'h0, ~a};
      5'b01100: return {32'h0, a} * {32'h0, b};
      5'b01101: return (b == 0) ? 64'h0 : {a % b, a / b};
      default:  return {32'h0, a + b};
    endcase
  endfunction
  assign alu_result = f_alu(alu_op, alu_a, alu_b);

  logic [31:0] m_gpr [16];
  logic [31:0] m_hi, m_lo;

  function automatic logic [31:0] mrd(input logic [3:0] s);
    return (s == 0 || s >= NR) ? 32'h0 : m_gpr[s];
  endfunction

  function automatic bit is_muldiv(input logic [4:0] op);
    return op == 5'b01100 || op == 5'b01101;
  endfunction

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] d, input logic [3:0] sa,
                                      input logic [3:0] sb, input logic [14:0] imm);
    return {op, d, sa, sb, imm};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_gpr[i] = 32'h0;
    m_hi = 32'h0;
    m_lo = 32'h0;
  endtask

  task automatic commit(input logic [31:0] w, input logic [63:0] res);
    if (is_muldiv(w[31:27])) begin
      m_hi = res[63:32];
      m_lo = res[31:0];
    end else if (w[26:23] != 0 && w[26:23] < NR) begin
      m_gpr[w[26:23]] = res[31:0];
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_regs();
    for (int s = 0; s < 16; s++) begin
      dbg_sel = 4'(s);
      #1;
      chk($sformatf("dbg_r%0d", s), dbg_data, mrd(4'(s)));
    end
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  endtask

  // cycle 0 = handshake edge; READ at 1, alu_start at 2, alu_done driven in cycle 2+lat
  task automatic issue(input logic [31:0] w, input int lat, input bit give_done, input bit noise,
                       input logic [31:0] ea, input logic [31:0] eb,
                       input logic [3:0] esel, input logic [31:0] edata);
    int last;
    @(negedge clk);
    chk("ir_ready_idle", ir_ready, 1);
    ir = w;
    ir_valid = 1'b1;
    @(negedge clk);
    ir_valid = 1'b0;
    chk("busy_read", busy, 1);
    chk("ir_ready_read", ir_ready, 0);
    chk("alu_a", alu_a, ea);
    chk("alu_b", alu_b, eb);
    chk("alu_op", alu_op, w[31:27]);
    chk("start_in_read", alu_start, 0);
    alu_done = noise;
    last = give_done ? 2 + lat : 2 + T;
    for (int c = 2; c <= last; c++) begin
      @(negedge clk);
      chk("alu_start", alu_start, c == 2);
      chk("err", err, !give_done && c == last);
      chk("wb_in_exec", wb_valid, 0);
      chk("alu_a_hold", alu_a, ea);
      chk("alu_b_hold", alu_b, eb);
      alu_done = (give_done && c == last) || (noise && c == 2);
      if (noise && c > 2 && c < last) begin
        ir_valid = 1'b1;
        ir = ~w;
      end else begin
        ir_valid = 1'b0;
      end
    end
    @(negedge clk);
    ir_valid = 1'b0;
    if (give_done) begin
      chk("wb_valid", wb_valid, 1);
      chk("wb_sel", wb_sel, esel);
      chk("wb_data", wb_data, edata);
      chk("ir_ready_wb", ir_ready, 0);
      chk("err_wb", err, 0);
      alu_done = noise;
      @(negedge clk);
    end
    alu_done = 1'b0;
    chk("ir_ready_back", ir_ready, 1);
    chk("busy_idle", busy, 0);
    chk("wb_idle", wb_valid, 0);
    chk("err_idle", err, 0);
  endtask

  typedef struct {
    logic [31:0] w;
    int          lat;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [3:0]  esel;
    logic [31:0] edata;
  } vec_t;

  vec_t tv [8];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] w, a, b;
    logic [63:0] res;
    bit gd, nz;
    int k;

    clr = 1'b1; ir_valid = 1'b0; ir = 32'h0; alu_done = 1'b0; dbg_sel = 4'd0;
    tv[0] = '{enc(5'b10011, 4'd1, 4'd0, 4'd0, 15'd5),      1, 32'd5,      32'd0,  4'd1,  32'd5};
    tv[1] = '{enc(5'b10011, 4'd2, 4'd0, 4'd0, 15'd7),      1, 32'd7,      32'd0,  4'd2,  32'd7};
    tv[2] = '{enc(5'b10011, 4'd3, 4'd0, 4'd0, 15'd9),      2, 32'd9,      32'd0,  4'd3,  32'd9};
    tv[3] = '{enc(5'b00011, 4'd4, 4'd2, 4'd3, 15'd0),      1, 32'd7,      32'd9,  4'd4,  32'd16};
    tv[4] = '{enc(5'b00011, 4'd0, 4'd2, 4'd3, 15'd0),      3, 32'd7,      32'd9,  4'd0,  32'd16};
    tv[5] = '{enc(5'b10011, 4'd13, 4'd0, 4'd0, 15'h7FFF),  1, 32'h7FFF,   32'd0,  4'd13, 32'h7FFF};
    tv[6] = '{enc(5'b00000, 4'd5, 4'd13, 4'd4, 15'd0),     2, 32'd0,      32'd16, 4'd5,  32'd16};
    tv[7] = '{enc(5'b10011, 4'd6, 4'd0, 4'd4, 15'h7FFF),   4, 32'h7FFF,   32'd16, 4'd6,  32'h800F};

    repeat (2) @(negedge clk);
    clr = 1'b0;
    model_reset();
    chk("rst_ir_ready", ir_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_alu_start", alu_start, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_wb_sel", wb_sel, 0);
    chk("rst_wb_data", wb_data, 0);
    check_regs();

    for (int i = 0; i < 8; i++) begin
      res = f_alu(tv[i].w[31:27], tv[i].ea, tv[i].eb);
      issue(tv[i].w, tv[i].lat, 1'b1, 1'b0, tv[i].ea, tv[i].eb, tv[i].esel, tv[i].edata);
      commit(tv[i].w, res);
      check_regs();
    end

    // r2 = ~r0, r3 = 2, then a 5-cycle mul into HI/LO
    w = enc(5'b00001, 4'd2, 4'd0, 4'd0, 15'd0);
    issue(w, 1, 1'b1, 1'b0, 32'd0, 32'd0, 4'd2, 32'hFFFF_FFFF);
    commit(w, 64'hFFFF_FFFF);
    w = enc(5'b10011, 4'd3, 4'd0, 4'd0, 15'd2);
    issue(w, 1, 1'b1, 1'b0, 32'd2, 32'd0, 4'd3, 32'd2);
    commit(w, 64'd2);
    w = enc(5'b01100, 4'd7, 4'd2, 4'd3, 15'd0);
    issue(w, 5, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd2, 4'd0, 32'hFFFF_FFFE);
    commit(w, 64'h1_FFFF_FFFE);
    chk("mul_hi", hi, 32'h1);
    chk("mul_lo", lo, 32'hFFFF_FFFE);
    check_regs();

    w = enc(5'b00011, 4'd8, 4'd1, 4'd1, 15'd0);
    issue(w, 0, 1'b0, 1'b0, 32'd5, 32'd5, 4'd0, 32'd0);
    check_regs();

    // clear during EXEC with r4 = 16; the later alu_done must not write anything
    dbg_sel = 4'd4;
    #1;
    chk("pre_clr_r4", dbg_data, 32'd16);
    @(negedge clk);
    ir = enc(5'b00011, 4'd4, 4'd2, 4'd3, 15'd0);
    ir_valid = 1'b1;
    @(negedge clk);
    ir_valid = 1'b0;
    @(negedge clk);
    chk("clr_seq_start", alu_start, 1);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    alu_done = 1'b1;
    chk("clr_busy", busy, 0);
    chk("clr_ir_ready", ir_ready, 1);
    chk("clr_alu_a", alu_a, 0);
    chk("clr_alu_op", alu_op, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("clr_no_wb", wb_valid, 0);
      chk("clr_still_idle", busy, 0);
    end
    alu_done = 1'b0;
    model_reset();
    check_regs();

    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 5);
      case (k)
        0: w[31:27] = 5'b10011;
        1: w[31:27] = 5'b00011;
        2: w[31:27] = 5'b00001;
        3: w[31:27] = 5'b01100;
        4: w[31:27] = 5'b01101;
        default: w[31:27] = 5'($urandom_range(0, 31));
      endcase
      w[26:0] = 27'($urandom);
      a = w[31] ? {17'h0, w[14:0]} : mrd(w[22:19]);
      b = mrd(w[18:15]);
      res = f_alu(w[31:27], a, b);
      gd = ($urandom_range(0, 9) != 0);
      nz = 1'($urandom_range(0, 1));
      issue(w, $urandom_range(1, 6), gd, nz, a, b,
            is_muldiv(w[31:27]) ? 4'd0 : w[26:23], res[31:0]);
      if (gd) commit(w, res);
      check_regs();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
Parametrised successor to the single-cycle control unit. It holds a general-purpose register file with r0 hardwired to zero, and dedicated HI/LO registers. It accepts one instruction word at a time through a valid/ready handshake, then sequences operand read, a start/done handshake with an external (possibly multi-cycle) ALU, and register writeback. A watchdog aborts the instruction if the ALU never answers.

Parameters:
DATA_W, 32, register and ALU operand width (at least 16)
NREGS, 16, number of GPRs (2 to 16); selectors at or above NREGS read 0 and writes to them are dropped
TIMEOUT, 64, maximum cycles to wait for alu_done before aborting (at least 2)

Ports:
clk  in  1  clock, rising edge
clr  in  1  synchronous active-high reset
ir_valid  in  1  instruction word offered
ir_ready  out  1  sequencer can accept an instruction
ir  in  32  instruction: op[31:27], dst[26:23], srcA[22:19], srcB[18:15], imm[14:0]
alu_a  out  DATA_W  operand A, held stable from READ through the end of EXEC
alu_b  out  DATA_W  operand B, held stable from READ through the end of EXEC
alu_op  out  5  latched opcode
alu_start  out  1  one-cycle pulse that starts the ALU
alu_done  in  1  ALU result valid
alu_result  in  2*DATA_W  {HI,LO} result
wb_valid  out  1  one-cycle pulse when a GPR or HI/LO is written
wb_sel  out  4  destination selector of the current writeback
wb_data  out  DATA_W  data being written back
busy  out  1  high whenever state is not IDLE
err  out  1  one-cycle pulse on a watchdog abort
hi  out  DATA_W  HI register
lo  out  DATA_W  LO register
dbg_sel  in  4  debug read selector
dbg_data  out  DATA_W  combinational read of GPR[dbg_sel]; reads 0 for selector 0 or selectors at or above NREGS

Behaviour:
- Reset: on clr=1 at a rising edge:
  - state goes to IDLE; all GPRs, hi and lo clear to 0.
  - alu_start, wb_valid, err and busy are 0; ir_ready=1; alu_a, alu_b, alu_op, wb_sel and wb_data are 0.
  - clr overrides any in-flight instruction; no writeback happens in that cycle.
- States:
  - IDLE to READ, when ir_valid and ir_ready: latch ir. ir_ready is 1 only in IDLE.
  - READ to EXEC, after 1 cycle.
    - alu_a = zero-extended imm[14:0] if op[4]=1, otherwise GPR[srcA].
    - alu_b = GPR[srcB].
    - alu_op = op.
  - EXEC: alu_start=1 on the first EXEC cycle only. alu_done is sampled from the following cycle onward.
    - alu_done=1: capture alu_result, go to WB.
    - Watchdog counter reaches TIMEOUT with no alu_done: pulse err, go to IDLE, no writes.
  - WB to IDLE, after 1 cycle, with wb_valid=1.
    - op=01100 (mul) or 01101 (div): hi and lo take alu_result; wb_sel=0; wb_data=LO; no GPR write.
    - Any other op: GPR[dst] takes result[DATA_W-1:0], except dst=0 or dst at or above NREGS (value discarded, wb_valid still pulses).
- Latency: the handshake edge at cycle 0 gives READ at 1, alu_start at 2, and the earliest done at 3. WB is the cycle after done is sampled. ir_ready returns the cycle after WB. Minimum 5 cycles per instruction.
- An alu_done arriving in IDLE, READ or WB, or in the alu_start cycle, is ignored.
- A GPR write becomes visible on dbg_data and to operand reads from the cycle after WB. Back-to-back dependent instructions therefore read updated values with no hazard.
- ir_valid may drop without having been accepted; nothing is latched unless the handshake completes.

Test Plan:
- Reset: assert clr for 2 cycles -> all dbg_data reads 0, hi=lo=0, ir_ready=1, busy=0.
- Immediate load: bench ALU returns A+B after 1 cycle; issue op=10011, dst=1, srcB=0, imm=0x0005 -> alu_a=5, alu_b=0, wb_valid with wb_sel=1, wb_data=5; GPR1=5 readable 1 cycle later; ir_ready back 5 cycles after acceptance.
- Register op: load r2=7 and r3=9, then issue op=00011, dst=4, srcA=2, srcB=3 -> alu_a=7, alu_b=9, r4=16. Then the same op with dst=0 -> wb_valid pulses, dbg_data for selector 0 stays 0.
- Multi-cycle mul: r2=0xFFFFFFFF, r3=2, op=01100; bench raises alu_done 5 cycles after alu_start with 0x1_FFFFFFFE -> hi=1, lo=0xFFFFFFFE; no GPR changes; alu_start is a single pulse.
- Watchdog: issue any op and never assert alu_done -> err pulses exactly TIMEOUT cycles after alu_start; no register changes; ir_ready=1 the next cycle.
- Reset mid-op: assert clr during EXEC while r4=16 -> the later alu_done is ignored, r4 reads 0, state is IDLE, and no wb_valid pulse occurs.
